// File: rtl/spi_out_array.sv
`default_nettype none
// ============================================================================
// Module   : spi_out_array
// Brief    : N-channel lockstep SPI broadcast transmitter with a double-buffered
//            word bank (shadow fills while the active bank shifts out).
// Revision : 1.0
// ============================================================================
module spi_out_array #(
    parameter int         NUM_CH  = 10,
    parameter int         DATA_W  = 16,
    parameter logic [7:0] PREFIX  = 8'hFF,
    parameter int         CLK_DIV = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [NUM_CH-1:0] cs,
    output logic [NUM_CH-1:0] sclk,
    output logic [NUM_CH-1:0] sdo,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_FRAME_BITS = 8 + DATA_W;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS + 1);
    localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PAD_W      = 1 << c_BIT_W;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_CH - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_TOP  = c_BIT_W'(c_FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shadow [NUM_CH];
    logic [DATA_W-1:0]   r_active [NUM_CH];
    logic [c_IDX_W-1:0]  r_wr_idx;
    logic                r_shadow_full;
    logic [c_DIV_W-1:0]  r_div;
    logic                r_phase;
    logic [c_BIT_W-1:0]  r_bit;

    logic w_accept;
    logic w_transfer;
    logic w_div_last;
    logic w_bit_end;
    logic w_cs_low;

    assign w_accept   = din_valid & din_ready;
    assign w_transfer = (r_state == S_IDLE) & r_shadow_full;
    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_bit_end  = w_div_last & r_phase;
    assign w_cs_low   = (r_state == S_SETUP) | (r_state == S_SHIFT) | (r_state == S_HOLD);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_shadow_full)                  w_state_nxt = S_SETUP;
            S_SETUP: if (w_div_last)                     w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && (r_bit == '0))     w_state_nxt = S_HOLD;
            S_HOLD:  if (w_div_last)                     w_state_nxt = S_GAP;
            S_GAP:   if (w_div_last)                     w_state_nxt = S_IDLE;
            default:                                     w_state_nxt = S_IDLE;
        endcase
    end

    // Transfer and accept never coincide: accept needs the shadow empty, transfer needs it full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_wr_idx      <= '0;
            r_shadow_full <= 1'b0;
        end else if (w_transfer) begin
            r_active      <= r_shadow;
            r_shadow_full <= 1'b0;
        end else if (w_accept) begin
            r_shadow[r_wr_idx] <= din;
            if (r_wr_idx == c_IDX_LAST) begin
                r_wr_idx      <= '0;
                r_shadow_full <= 1'b1;
            end else begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            // Phase 0 = sclk low half of a bit, phase 1 = sclk high half.
            if (r_state != S_SHIFT) begin
                r_phase <= 1'b0;
            end else if (w_div_last) begin
                r_phase <= ~r_phase;
            end

            if (w_transfer) begin
                r_bit <= c_BIT_TOP;
            end else if ((r_state == S_SHIFT) && w_bit_end && (r_bit != '0)) begin
                r_bit <= r_bit - 1'b1;
            end
        end
    end

    assign din_ready  = reset & ~r_shadow_full;
    assign cs         = {NUM_CH{~w_cs_low}};
    assign sclk       = {NUM_CH{(r_state == S_SHIFT) & r_phase}};
    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_GAP) & w_div_last;

    // r_bit sits at the MSB during SETUP and at 0 during HOLD, so one select covers all three states.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic [c_PAD_W-1:0] w_frame;
            assign w_frame = c_PAD_W'({PREFIX, r_active[g]});
            assign sdo[g]  = w_cs_low & w_frame[r_bit];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/spi_out_array.md
Name: spi_out_array

Overview:
- Parametrised N-channel SPI broadcast transmitter for the backlight dimming path.
- Collects one DATA_W-bit word per channel from the upstream word stream into a shadow bank. Each word holds the address in its upper byte and the duty value in its lower bits.
- Then shifts all channels out in lockstep as PREFIX + word frames.
- Double-buffered: the next frame loads while the current one transmits, with a ready/valid handshake and per-frame completion pulse.

Parameters:
- NUM_CH, 10, number of driver channels (>=1)
- DATA_W, 16, per-channel word width; multiple of 8, >=8
- PREFIX, 8'hFF, 8-bit header sent before each word
- CLK_DIV, 4, system clocks per SCLK half-period (>=1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- din  in  DATA_W  channel word; ch k = k-th accepted word of a frame
- din_valid  in  1  din qualifier
- din_ready  out  1  = reset & ~shadow_full
- cs  out  NUM_CH  per-channel chip select, active low
- sclk  out  NUM_CH  per-channel SPI clock, idle low
- sdo  out  NUM_CH  per-channel serial data, MSB first
- busy  out  1  high from cs fall through end of GAP
- frame_done  out  1  one-cycle pulse at end of GAP

Behaviour:
- Reset (reset==0 at a clock edge), effective next cycle and aborting any frame:
  - cs all 1, sclk all 0, sdo all 0, busy 0, frame_done 0.
  - Shadow bank and active bank cleared; wr_idx=0; shadow_full=0; FSM=IDLE.
  - din_ready=0 while reset low.
- Load:
  - A word is accepted when din_valid & din_ready at a clock edge.
  - Accepted word goes to shadow[wr_idx]; wr_idx++.
  - On acceptance with wr_idx==NUM_CH-1: wr_idx wraps to 0 and shadow_full sets.
  - While shadow_full, din is ignored.
- Transfer, in IDLE with shadow_full=1:
  - Next edge: active<=shadow, shadow_full<=0, FSM->SETUP.
  - cs all 0, busy=1 in that same next cycle.
  - The last word's accept edge and the transfer edge are distinct: transfer happens one cycle after shadow_full sets.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - SETUP: CLK_DIV cycles; cs low, sclk low, sdo = bit FRAME_BITS-1 of the frame.
  - SHIFT: FRAME_BITS = 8+DATA_W bits, each 2*CLK_DIV cycles.
    - First CLK_DIV cycles: sclk low.
    - Next CLK_DIV cycles: sclk high.
    - sdo changes only at the start of a bit, i.e. the sclk low phase; slave samples on the rising edge.
    - Frame = {PREFIX, active[ch]}, MSB first.
  - HOLD: CLK_DIV cycles; sclk low, cs low, sdo holds last bit.
  - GAP: CLK_DIV cycles; cs high, sdo 0.
    - frame_done=1 during the final GAP cycle; busy falls with it.
    - The next frame may start (cs low) no earlier than the cycle after.
- Totals:
  - Frame length in cycles = CLK_DIV*(2*FRAME_BITS+3).
  - cs low duration = CLK_DIV*(2*FRAME_BITS+2).
  - Defaults: 204 and 200.
- All channels share one timing engine: cs and sclk bits are identical across channels; only sdo differs.
- Loading continues during a frame. When the shadow refills mid-frame, din_ready stays 0 until the transfer edge after returning to IDLE.
- Counters:
  - Divider counts 0..CLK_DIV-1.
  - Bit counter counts FRAME_BITS-1 down to 0, width $clog2(FRAME_BITS+1).
  - No wrap beyond these bounds.

Test Plan:
- Reset values:
  - Hold reset=0 for 3 cycles with din_valid=1 -> cs=10'h3FF, sclk=0, sdo=0, busy=0, din_ready=0.
  - Release -> din_ready=1 next cycle.
- Single frame, defaults:
  - Feed 10 consecutive words 16'h0100+k -> cs falls 1 cycle after 10th accept.
  - ch0 sdo = FF,01,00 across 24 sclk rising edges; ch9 lower byte = 09.
  - cs low 200 cycles; frame_done pulse at cycle 204 after cs fall.
- Back-to-back:
  - Stream 20 words with din_valid=1 -> first 10 plus transfer, then 10 more accepted during frame 1; din_ready=0 afterwards.
  - Second cs fall exactly 2 cycles after frame_done (GAP end -> IDLE -> transfer); second frame contents correct.
- Valid gaps:
  - Toggle din_valid every other cycle -> only valid-cycle words land; transfer occurs after the 10th accepted word, not the 10th cycle.
- Reset mid-frame:
  - Assert reset during SHIFT bit 10 with 4 words preloaded in shadow -> reset outputs next cycle.
  - After release, 10 new words give a clean frame with the new data only.
- Param corner:
  - NUM_CH=3, DATA_W=8, CLK_DIV=1 -> 16-bit frames, sclk period 2 cycles, cs low 34 cycles, frame_done at cycle 35.
